seg_capture: RTL and testbench
==============================

Name: seg_capture

Overview:
- Receive-side counterpart of the 7-segment digit encoder. Samples a multiplexed, active-low 8-segment bus (dp + g..a) and its active-low digit-select lines, as driven to a scanned display.
- Waits until each pattern is stable, then recovers the 0-9 value and dot for each digit position and holds them in per-digit registers.
- Used for loopback self-test of display drivers and for reading external scanned displays into the fabric.

Parameters:
- NDIG, 6: number of digit positions, i.e. the width of sel.
- STABLE_CYC, 4: consecutive identical synchronized samples required before a capture (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- seg  in  8  segment bus, active-low; bit7 = dp, bits6..0 = g..a
- sel  in  NDIG  digit select, active-low, one-hot when driving
- dig_out  out  4*NDIG  captured digit per position; position i occupies [4i+3:4i]
- dot_out  out  NDIG  captured dot per position, active-high
- valid_out  out  NDIG  position holds a decoded 0-9 value
- upd  out  1  one-cycle pulse: a position register was written
- upd_idx  out  $clog2(NDIG)  index written; meaningful only while upd=1
- err  out  1  one-cycle pulse: unrecognised pattern or illegal select

Behaviour:
- Reset (async, active-high): dig_out=0, dot_out=0, valid_out=0, upd=0, upd_idx=0, err=0. Synchronizer flops load idle values (seg=8'hFF, sel all 1). Stability counter=0. Reset mid-capture discards the pending window; no pulse is emitted.
- Input path: 2-flop synchronizer on {sel,seg}, then a one-word history register.
- Stability counter:
  - If the synchronized word equals the history word, the counter increments, saturating at STABLE_CYC.
  - Any change resets the counter to 1.
  - A capture event fires on the cycle the counter reaches STABLE_CYC. It fires once per stable window; a pattern held longer never re-fires.
- Latency: pins stable from edge k, so outputs and pulses update at edge k+2+STABLE_CYC (k+6 by default).
- Capture decision:
  - sel all 1 (blanking interval): no action, no pulse.
  - sel with more than one 0: err=1, no register write.
  - sel exactly one 0 at position i: write position i and pulse upd with upd_idx=i. dot_out[i] = ~seg[7]. Then by pattern:
    - ~seg[6:0] matches digit d (0-9): dig_out[i]=d, valid_out[i]=1.
    - ~seg[6:0]==0 (blank, the encoder's output for codes >9): dig_out[i]=4'hF, valid_out[i]=0, no err.
    - Any other pattern: dig_out[i] unchanged, valid_out[i]=0, err=1 (upd still pulses).
- Active-high segment table, bit order g..a: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
- upd and err are registered, high for exactly one cycle, and may be high together.
- Positions not addressed by a capture hold their values indefinitely.

Decomposition:
- seg_pkg holds:
  - SEG_LUT: 10-entry active-high 7-bit pattern constant.
  - SEG_BLANK = 7'h00.
  - Default NDIG and STABLE_CYC constants.
  - Decode result struct {digit[3:0], match, blank}.
- Sub-module seg_pattern_dec: purely combinational. Takes 7 active-high segments and returns the decode struct; used once at the capture point.

Test Plan:
- Digit 3 at position 2: seg=8'hB0, sel=6'b111011 held 10 cycles -> after 6 cycles dig_out[11:8]=3, valid_out[2]=1, dot_out[2]=0; upd=1 for one cycle with upd_idx=2; no further upd while held.
- Digit 8 with dot at position 0: seg=8'h00, sel=6'b111110 -> dig_out[3:0]=8, dot_out[0]=1, valid_out[0]=1.
- Glitch: seg=8'hB0, sel=6'b111011 held 3 cycles, then sel=6'b111111 -> no upd, no err, outputs unchanged.
- Blank and bad pattern at position 5:
  - seg=8'hFF, sel=6'b011111 -> dig_out[23:20]=F, valid_out[5]=0, upd=1, err=0.
  - Then seg=8'hFE -> err=1, valid_out[5]=0, dig_out[23:20] stays F.
- Illegal select: seg=8'hB0, sel=6'b111100 held -> err=1 once, upd=0, all registers unchanged.
- Full scan of 6 digits, 12 cycles each, values 1..6, with rst asserted for 1 cycle mid-scan -> immediate all-zero outputs; after release only post-reset digits appear, each with exactly one upd.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the scanned 7-segment display capture block.
package seg_pkg;

  localparam int SEG_NDIG       = 6;
  localparam int SEG_STABLE_CYC = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high g..a patterns; index d holds the pattern for digit d.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [3:0] digit;
    logic       match;
    logic       blank;
  } seg_dec_t;

endpackage

// File: rtl/seg_pattern_dec.sv
// Combinational 7-segment pattern recogniser: active-high g..a in, digit/match/blank out.
module seg_pattern_dec
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output seg_dec_t   o_dec
);

  always_comb begin
    o_dec       = '0;
    o_dec.blank = (i_seg == SEG_BLANK);
    for (int d = 0; d < 10; d++) begin
      if (i_seg == SEG_LUT[d]) begin
        o_dec.match = 1'b1;
        o_dec.digit = 4'(d);
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Samples a multiplexed active-low segment/select bus, waits for stability,
// and latches the decoded digit and dot for the addressed position.
module seg_capture
  import seg_pkg::*;
#(
  parameter int NDIG       = SEG_NDIG,
  parameter int STABLE_CYC = SEG_STABLE_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg,
  input  logic [NDIG-1:0]         sel,
  output logic [4*NDIG-1:0]       dig_out,
  output logic [NDIG-1:0]         dot_out,
  output logic [NDIG-1:0]         valid_out,
  output logic                    upd,
  output logic [$clog2(NDIG)-1:0] upd_idx,
  output logic                    err
);

  localparam int W  = NDIG + 8;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int IW = $clog2(NDIG);

  logic [W-1:0]  r_sync1, r_sync2, r_hist;
  logic [CW-1:0] r_cnt;
  logic          r_fire;

  logic          w_same;
  logic [7:0]    w_cap_seg;
  logic [NDIG-1:0] w_act;
  logic [6:0]    w_seg_ah;
  logic          w_single, w_multi, w_bad;
  logic [IW-1:0] w_idx;
  seg_dec_t      w_dec;

  logic [NDIG-1:0][3:0] r_dig;
  logic [NDIG-1:0]      r_dot, r_valid;

  assign w_same = (r_sync2 == r_hist);

  // Idle bus is all ones (segments off, no digit selected).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_hist  <= '1;
      r_cnt   <= '0;
      r_fire  <= 1'b0;
    end else begin
      r_sync1 <= {sel, seg};
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (w_same) begin
        if (r_cnt != CW'(STABLE_CYC)) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= CW'(1);
      end
      // Only the transition into saturation fires, so a long hold never re-fires.
      r_fire <= w_same && (r_cnt == CW'(STABLE_CYC - 1));
    end
  end

  // While r_fire is high, r_hist still holds the word of the stable window.
  assign w_cap_seg = r_hist[7:0];
  assign w_act     = ~r_hist[W-1:8];
  assign w_seg_ah  = ~w_cap_seg[6:0];

  seg_pattern_dec u_dec (
    .i_seg (w_seg_ah),
    .o_dec (w_dec)
  );

  assign w_single = $onehot(w_act);
  assign w_multi  = (w_act != '0) && !w_single;
  assign w_bad    = !w_dec.match && !w_dec.blank;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_act[i]) w_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig   <= '0;
      r_dot   <= '0;
      r_valid <= '0;
    end else if (r_fire && w_single) begin
      for (int i = 0; i < NDIG; i++) begin
        if (w_act[i]) begin
          r_dot[i] <= ~w_cap_seg[7];
          if (w_dec.match) begin
            r_dig[i]   <= w_dec.digit;
            r_valid[i] <= 1'b1;
          end else if (w_dec.blank) begin
            r_dig[i]   <= 4'hF;
            r_valid[i] <= 1'b0;
          end else begin
            r_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd     <= 1'b0;
      upd_idx <= '0;
      err     <= 1'b0;
    end else begin
      upd <= r_fire && w_single;
      err <= r_fire && (w_multi || (w_single && w_bad));
      if (r_fire && w_single) upd_idx <= w_idx;
    end
  end

  assign dig_out   = r_dig;
  assign dot_out   = r_dot;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: expected pulses and register state queued at drive time.
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic [23:0] dig_out;
  logic [5:0]  dot_out, valid_out;
  logic        upd, err;
  logic [2:0]  upd_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int upd_seen = 0;

  typedef struct {
    int          cyc;
    logic        upd;
    logic [2:0]  idx;
    logic        err;
    logic [23:0] dig;
    logic [5:0]  dot;
    logic [5:0]  vld;
  } exp_t;

  exp_t q[$];
  logic [23:0] m_dig;
  logic [5:0]  m_dot, m_vld;

  seg_capture #(.NDIG(6), .STABLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .seg(seg), .sel(sel),
    .dig_out(dig_out), .dot_out(dot_out), .valid_out(valid_out),
    .upd(upd), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tb_digit(input logic [6:0] p);
    case (p)
      7'h3F: return 0; 7'h06: return 1; 7'h5B: return 2; 7'h4F: return 3;
      7'h66: return 4; 7'h6D: return 5; 7'h7D: return 6; 7'h07: return 7;
      7'h7F: return 8; 7'h6F: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic predict(input logic [7:0] s, input logic [5:0] sl, input int at);
    exp_t e;
    logic [5:0] act;
    logic [6:0] p;
    int d, ix;
    act = ~sl;
    if (act == 6'd0) return;
    e.cyc = at; e.upd = 1'b0; e.idx = 3'd0; e.err = 1'b0;
    if ($countones(act) > 1) begin
      e.err = 1'b1;
    end else begin
      ix = 0;
      for (int i = 0; i < 6; i++) if (act[i]) ix = i;
      e.upd = 1'b1; e.idx = 3'(ix);
      m_dot[ix] = ~s[7];
      p = ~s[6:0];
      d = tb_digit(p);
      if (d >= 0) begin
        m_dig[ix*4 +: 4] = 4'(d); m_vld[ix] = 1'b1;
      end else if (p == 7'h00) begin
        m_dig[ix*4 +: 4] = 4'hF; m_vld[ix] = 1'b0;
      end else begin
        m_vld[ix] = 1'b0; e.err = 1'b1;
      end
    end
    e.dig = m_dig; e.dot = m_dot; e.vld = m_vld;
    q.push_back(e);
  endtask

  // Inputs change #1 after a posedge; the pulse lands 7 counted edges later.
  task automatic apply(input logic [7:0] s, input logic [5:0] sl, input int hold);
    seg = s; sel = sl;
    if (hold >= 4) predict(s, sl, cyc + 7);
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(8'hFF, 6'h3F, 10);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_pulse: expected at cycle %0d, no pulse observed (now %0d)", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (upd) upd_seen++;
      if (upd || err) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: cycle %0d upd=%0b err=%0b idx=%0d, none required", cyc, upd, err, upd_idx);
        end else begin
          e = q.pop_front();
          if (cyc !== e.cyc || upd !== e.upd || err !== e.err || (e.upd && upd_idx !== e.idx) ||
              dig_out !== e.dig || dot_out !== e.dot || valid_out !== e.vld) begin
            bad++;
            $display("FAIL pulse_event: got cyc=%0d upd=%0b idx=%0d err=%0b dig=%h dot=%b vld=%b, need cyc=%0d upd=%0b idx=%0d err=%0b dig=%h dot=%b vld=%b",
                     cyc, upd, upd_idx, err, dig_out, dot_out, valid_out,
                     e.cyc, e.upd, e.idx, e.err, e.dig, e.dot, e.vld);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; seg = 8'hFF; sel = 6'h3F;
    m_dig = '0; m_dot = '0; m_vld = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dig_out !== 24'h0 || dot_out !== 6'h0 || valid_out !== 6'h0 || upd !== 1'b0 || upd_idx !== 3'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: dig=%h dot=%b vld=%b upd=%b idx=%0d err=%b, need all zero", dig_out, dot_out, valid_out, upd, upd_idx, err);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_digit3();
    int u0;
    u0 = upd_seen;
    apply(8'hB0, 6'b111011, 10);
    total++;
    if (dig_out[11:8] !== 4'd3 || valid_out[2] !== 1'b1 || dot_out[2] !== 1'b0) begin
      bad++;
      $display("FAIL digit3_pos2: dig=%h vld=%b dot=%b, need 3/1/0", dig_out[11:8], valid_out[2], dot_out[2]);
    end
    total++;
    if (upd_seen - u0 !== 1) begin
      bad++;
      $display("FAIL digit3_single_upd: %0d upd pulses, need 1", upd_seen - u0);
    end
    idle();
  endtask

  task automatic test_digit8_dot();
    apply(8'h00, 6'b111110, 10);
    total++;
    if (dig_out[3:0] !== 4'd8 || dot_out[0] !== 1'b1 || valid_out[0] !== 1'b1) begin
      bad++;
      $display("FAIL digit8_dot: dig=%h dot=%b vld=%b, need 8/1/1", dig_out[3:0], dot_out[0], valid_out[0]);
    end
    idle();
  endtask

  task automatic test_glitch();
    logic [23:0] d0;
    logic [5:0]  t0, v0;
    int u0;
    d0 = dig_out; t0 = dot_out; v0 = valid_out; u0 = upd_seen;
    apply(8'hB0, 6'b111011, 3);
    idle();
    total++;
    if (dig_out !== d0 || dot_out !== t0 || valid_out !== v0 || upd_seen !== u0) begin
      bad++;
      $display("FAIL glitch_hold: dig=%h dot=%b vld=%b upds=%0d, need dig=%h dot=%b vld=%b upds=%0d",
               dig_out, dot_out, valid_out, upd_seen - u0, d0, t0, v0, 0);
    end
  endtask

  task automatic test_blank_bad();
    apply(8'hFF, 6'b011111, 10);
    total++;
    if (dig_out[23:20] !== 4'hF || valid_out[5] !== 1'b0) begin
      bad++;
      $display("FAIL blank_pos5: dig=%h vld=%b, need F/0", dig_out[23:20], valid_out[5]);
    end
    apply(8'hFE, 6'b011111, 10);
    total++;
    if (dig_out[23:20] !== 4'hF || valid_out[5] !== 1'b0) begin
      bad++;
      $display("FAIL badpat_pos5: dig=%h vld=%b, need F/0", dig_out[23:20], valid_out[5]);
    end
    idle();
  endtask

  task automatic test_illegal_sel();
    logic [23:0] d0;
    logic [5:0]  v0;
    d0 = dig_out; v0 = valid_out;
    apply(8'hB0, 6'b111100, 10);
    total++;
    if (dig_out !== d0 || valid_out !== v0) begin
      bad++;
      $display("FAIL illegal_sel_regs: dig=%h vld=%b, need dig=%h vld=%b", dig_out, valid_out, d0, v0);
    end
    idle();
  endtask

  task automatic test_scan_reset();
    logic [7:0] s;
    logic [5:0] sl;
    int u0;
    logic [6:0] lut [10];
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    u0 = 0;
    for (int j = 0; j < 6; j++) begin
      s  = {1'b1, ~lut[j+1]};
      sl = ~(6'd1 << j);
      if (j != 3) begin
        apply(s, sl, 12);
      end else begin
        apply(s, sl, 3);
        rst = 1'b1;
        #1;
        q.delete();
        m_dig = '0; m_dot = '0; m_vld = '0;
        total++;
        if (dig_out !== 24'h0 || dot_out !== 6'h0 || valid_out !== 6'h0 || upd !== 1'b0 || err !== 1'b0) begin
          bad++;
          $display("FAIL scan_reset_zero: dig=%h dot=%b vld=%b upd=%b err=%b, need zero", dig_out, dot_out, valid_out, upd, err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        u0 = upd_seen;
        predict(s, sl, cyc + 7);
        repeat (8) @(posedge clk);
        #1;
      end
    end
    idle();
    total++;
    if (dig_out !== 24'h654000 || valid_out !== 6'b111000 || dot_out !== 6'h0) begin
      bad++;
      $display("FAIL scan_final: dig=%h vld=%b dot=%b, need 654000/111000/000000", dig_out, valid_out, dot_out);
    end
    total++;
    if (upd_seen - u0 !== 3) begin
      bad++;
      $display("FAIL scan_upd_count: %0d upd after reset, need 3", upd_seen - u0);
    end
  endtask

  initial begin
    test_reset();
    test_digit3();
    test_digit8_dot();
    test_glitch();
    test_blank_bad();
    test_illegal_sel();
    test_scan_reset();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d events left, need 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
